ring_freq_meter: RTL and testbench

Measurement stage directly downstream of the self-timed ring oscillator. It takes the free-running ring `ack` toggle (`osc`) and prescales it in the oscillator's own domain. It then synchronizes the prescaled signal into the system clock domain and counts its toggles over a fixed gate window. Each window yields one frequency sample on a valid/ready output port. A live stall indicator flags a ring that has stopped oscillating.

---
 rtl/ring_meas_pkg.sv | 19 +
 rtl/osc_toggle_sync.sv | 52 +++++
 rtl/ring_freq_meter.sv | 196 +++++++++++++++++++
 tb/tb_ring_freq_meter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_meas_pkg.sv
// ring_meas_pkg
// Shared definitions for the ring oscillator frequency meter: the measurement
// FSM state encoding, the synchronizer depth and the arming (flush) length.
`timescale 1ns/1ps
package ring_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2
    } meas_state_t;

    // Flops between the osc-domain prescaler MSB and the history flop.
    localparam int SYNC_STAGES = 2;

    // Cycles spent in ARM so stale synchronizer contents never reach a window.
    localparam int ARM_CYCLES = 3;

endpackage

// File: rtl/osc_toggle_sync.sv
// osc_toggle_sync
// Prescales the free-running ring oscillator in its own domain and brings the
// prescaler MSB into the clk domain, producing a one-cycle toggle strobe for
// every MSB transition. This is the only logic clocked by osc.
//
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-low reset (clears both domains)
//   osc  in  ring oscillator output, asynchronous to clk
//   tog  out high for one clk cycle per synchronized MSB edge
`timescale 1ns/1ps
module osc_toggle_sync
    import ring_meas_pkg::*;
#(
    parameter int PRESC_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic osc,
    output logic tog
);

    logic [PRESC_W-1:0]     div_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   msb;

    // Prescaler: one MSB transition per 2^(PRESC_W-1) osc rising edges.
    always_ff @(posedge osc or negedge rst) begin
        if (!rst) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign msb = div_reg[PRESC_W-1];

    // Bit 0 is the metastability-catching stage; the top bit is the settled copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], msb};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign tog = sync_reg[SYNC_STAGES-1] ^ hist_reg;

endmodule

// File: rtl/ring_freq_meter.sv
// ring_freq_meter
// Counts synchronized prescaler toggles of a self-timed ring oscillator over
// fixed gate windows and presents one sample per window on a valid/ready port.
// A free-running quiet counter flags a ring that has stopped oscillating.
//
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   osc        in  ring oscillator output (asynchronous)
//   en         in  run back-to-back gate windows while high
//   out_valid  out sample held in the output register
//   out_ready  in  consumer accepts the sample
//   out_count  out toggles counted in the window (saturating)
//   out_ovf    out count saturated during the window
//   out_lost   out a sample was dropped since the last accepted one
//   stalled    out no toggle seen for STALL_CYCLES cycles
`timescale 1ns/1ps
module ring_freq_meter
    import ring_meas_pkg::*;
#(
    parameter int GATE_CYCLES  = 1024,
    parameter int CNT_W        = 16,
    parameter int PRESC_W      = 4,
    parameter int STALL_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_lost,
    output logic             stalled
);

    localparam int WIN_W   = $clog2(GATE_CYCLES);
    localparam int QUIET_W = $clog2(STALL_CYCLES + 1);

    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [1:0]         ARM_LAST  = 2'(ARM_CYCLES - 1);
    localparam logic [QUIET_W-1:0] QUIET_MAX = QUIET_W'(STALL_CYCLES);

    logic tog;

    osc_toggle_sync #(
        .PRESC_W (PRESC_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .osc (osc),
        .tog (tog)
    );

    // ------------------------------------------------------------------
    // Measurement FSM and window counters
    // ------------------------------------------------------------------
    meas_state_t      state_reg;
    logic [1:0]       arm_reg;
    logic [WIN_W-1:0] win_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;

    logic             sat_hit;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic             sample_fire;

    // Next count including this cycle's toggle; also the value offered at
    // window end so the final cycle's toggle is never lost.
    assign sat_hit  = tog && (cnt_reg == CNT_MAX);
    assign cnt_next = sat_hit ? cnt_reg : cnt_reg + CNT_W'(tog);
    assign ovf_next = ovf_reg | sat_hit;

    // Window completion produces a sample even if en falls in that same cycle.
    assign sample_fire = (state_reg == GATE) && (win_reg == WIN_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            arm_reg   <= '0;
            win_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    arm_reg <= '0;
                    win_reg <= '0;
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                    if (en) begin
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state_reg <= IDLE;
                        arm_reg   <= '0;
                    end else if (arm_reg == ARM_LAST) begin
                        state_reg <= GATE;
                        arm_reg   <= '0;
                    end else begin
                        arm_reg <= arm_reg + 1'b1;
                    end
                end
                GATE: begin
                    if (win_reg == WIN_LAST) begin
                        win_reg   <= '0;
                        cnt_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        state_reg <= en ? GATE : IDLE;
                    end else if (!en) begin
                        // Abort: partial window is discarded.
                        win_reg   <= '0;
                        cnt_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        win_reg <= win_reg + 1'b1;
                        cnt_reg <= cnt_next;
                        ovf_reg <= ovf_next;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single-entry output register with lost-sample tracking
    // ------------------------------------------------------------------
    logic             out_valid_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_ovf_reg;
    logic             out_lost_reg;
    logic             lost_pend_reg;

    logic accept;
    logic load;
    logic pend_kept;

    assign accept = out_valid_reg && out_ready;
    assign load   = sample_fire && (!out_valid_reg || out_ready);

    // Accepting the sample that carried the loss report retires it; this is
    // applied before a same-cycle load so one loss is never reported twice.
    assign pend_kept = lost_pend_reg && !(accept && out_lost_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_ovf_reg   <= 1'b0;
            out_lost_reg  <= 1'b0;
            lost_pend_reg <= 1'b0;
        end else begin
            if (load) begin
                out_valid_reg <= 1'b1;
                out_count_reg <= cnt_next;
                out_ovf_reg   <= ovf_next;
                out_lost_reg  <= pend_kept;
            end else if (accept) begin
                out_valid_reg <= 1'b0;
            end
            lost_pend_reg <= (sample_fire && !load) || pend_kept;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_lost  = out_lost_reg;

    // ------------------------------------------------------------------
    // Stall detector, independent of en and the FSM
    // ------------------------------------------------------------------
    logic [QUIET_W-1:0] quiet_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quiet_reg <= '0;
        end else if (tog) begin
            quiet_reg <= '0;
        end else if (quiet_reg != QUIET_MAX) begin
            quiet_reg <= quiet_reg + 1'b1;
        end
    end

    assign stalled = (quiet_reg == QUIET_MAX);

endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter
// Directed bench for ring_freq_meter: clk 10 ns, osc 20 ns (64 counted
// toggles per 1024-cycle window with PRESC_W=4). A second instance with
// CNT_W=4 exercises saturation. Outputs are sampled on the falling clk edge.
`timescale 1ns/1ps
module tb_ring_freq_meter;
    import ring_meas_pkg::*;

    localparam int G = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        osc = 1'b0;
    logic        osc_run = 1'b1;
    logic        en = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [15:0] out_count;
    logic        out_ovf;
    logic        out_lost;
    logic        stalled;

    logic        ready2 = 1'b1;
    logic        valid2;
    logic [3:0]  count2;
    logic        ovf2;
    logic        lost2;
    logic        stalled2;

    int n_checks = 0;
    int n_errors = 0;

    ring_freq_meter dut (
        .clk       (clk),
        .rst       (rst),
        .osc       (osc),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_lost  (out_lost),
        .stalled   (stalled)
    );

    ring_freq_meter #(.CNT_W(4)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .osc       (osc),
        .en        (en),
        .out_valid (valid2),
        .out_ready (ready2),
        .out_count (count2),
        .out_ovf   (ovf2),
        .out_lost  (lost2),
        .stalled   (stalled2)
    );

    always #5 clk = ~clk;

    // osc edges sit 3 ns off the clk grid; period 20 ns while running.
    initial begin
        #3;
        forever begin
            #10;
            if (osc_run) osc = ~osc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Count falling edges until out_valid is seen high, bounded by budget.
    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    int  n;
    logic seen;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_valid",   32'(out_valid), 32'd0);
        check_eq("rst_count",   32'(out_count), 32'd0);
        check_eq("rst_ovf",     32'(out_ovf),   32'd0);
        check_eq("rst_lost",    32'(out_lost),  32'd0);
        check_eq("rst_stalled", 32'(stalled),   32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // First sample latency: en seen at the next rising edge, then
        // 3 ARM + G GATE cycles, valid visible at the following falling edge.
        en = 1'b1;
        wait_valid("first", 2000, n);
        check_eq("first_latency", 32'(n), 32'(G + 4));
        check_eq("first_count", 32'(out_count), 32'd64);
        check_eq("first_ovf",   32'(out_ovf),   32'd0);
        check_eq("first_lost",  32'(out_lost),  32'd0);
        check_eq("sat_valid",   32'(valid2),    32'd1);
        check_eq("sat_count",   32'(count2),    32'd15);
        check_eq("sat_ovf",     32'(ovf2),      32'd1);

        // Back-to-back windows: one falling edge consumed by the drop check.
        @(negedge clk);
        check_eq("accept_drop", 32'(out_valid), 32'd0);
        wait_valid("second", 2000, n);
        check_eq("period", 32'(n), 32'(G - 1));
        check_eq("second_count", 32'(out_count), 32'd64);

        // Backpressure: hold this sample through three window ends.
        out_ready = 1'b0;
        repeat (G + 10) @(negedge clk);
        check_eq("held_valid", 32'(out_valid), 32'd1);
        check_eq("held_count", 32'(out_count), 32'd64);
        check_eq("held_lost",  32'(out_lost),  32'd0);
        repeat (2 * G + 90) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("held_accept", 32'(out_valid), 32'd0);
        wait_valid("after_loss", 2000, n);
        check_eq("loss_flag",  32'(out_lost),  32'd1);
        check_eq("loss_count", 32'(out_count), 32'd64);
        @(negedge clk);
        wait_valid("post_loss", 2000, n);
        check_eq("loss_clear", 32'(out_lost),  32'd0);
        check_eq("post_count", 32'(out_count), 32'd64);

        // Abort at window cycle ~500: no sample, FSM back to IDLE.
        repeat (500) @(negedge clk);
        en = 1'b0;
        seen = 1'b0;
        repeat (G + 100) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_eq("abort_nosample", 32'(seen), 32'd0);
        check_eq("abort_idle", 32'(dut.state_reg), 32'(IDLE));
        en = 1'b1;
        wait_valid("rearm", 2000, n);
        check_eq("rearm_latency", 32'(n), 32'(G + 4));
        check_eq("rearm_count",   32'(out_count), 32'd64);

        // Stall: stop osc.
        osc_run = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("stall_early", 32'(stalled), 32'd0);
        repeat (4100) @(negedge clk);
        check_eq("stall_set", 32'(stalled), 32'd1);
        wait_valid("quiet", 2000, n);
        check_eq("quiet_count", 32'(out_count), 32'd0);
        check_eq("quiet_ovf",   32'(out_ovf),   32'd0);
        osc_run = 1'b1;
        n = 0;
        while (n < 60 && stalled) begin
            @(negedge clk);
            n++;
        end
        check_eq("stall_clear", 32'(stalled), 32'd0);

        // Reset mid-window with a held sample.
        out_ready = 1'b0;
        wait_valid("pre_reset", 2000, n);
        repeat (300) @(negedge clk);
        check_eq("pre_reset_held", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid),     32'd0);
        check_eq("mid_rst_count", 32'(out_count),     32'd0);
        check_eq("mid_rst_ovf",   32'(out_ovf),       32'd0);
        check_eq("mid_rst_lost",  32'(out_lost),      32'd0);
        check_eq("mid_rst_stall", 32'(stalled),       32'd0);
        check_eq("mid_rst_state", 32'(dut.state_reg), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
